mdio_slave: RTL

PHY-side MDIO responder for Clause 22 management frames. It oversamples externally driven MDC and MDIO on the system clock and decodes preamble, start, opcode, PHY address and register address. Write frames become a single-cycle register write strobe. Read frames fetch a 16-bit value from a host-side register file and drive it back onto MDIO. It sits inside simulated or FPGA-hosted PHY models, opposite the team's MDIO master.

---
 rtl/mdio_pkg.sv | 29 ++
 rtl/mdio_edge_sync.sv | 52 +++++
 rtl/mdio_slave.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, field widths and FSM state encoding for the Clause 22 MDIO responder.
package mdio_pkg;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;
  localparam int HDR_W   = 2 + PHYAD_W + REGAD_W;
  localparam int CNT_W   = 5;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  // Frame-body bit index of a sample, counted from ST bit 0 = 0.
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = 5'd13;
  localparam logic [CNT_W-1:0] CNT_TA1      = 5'd14;
  localparam logic [CNT_W-1:0] CNT_TA2      = 5'd15;
  localparam logic [CNT_W-1:0] CNT_LAST     = 5'd31;
  localparam logic [CNT_W-1:0] RD_BITS      = 5'd16;

  typedef enum logic [2:0] {
    ST_PREAMBLE,
    ST_START,
    ST_HEADER,
    ST_TA,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } state_e;
endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronizes MDC/MDIO into the clk domain and produces registered MDC rise/fall pulses
// with the synchronized MDIO value aligned to them.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdc_fall,
  output logic mdio_s
);
  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic mdc_prev_q, mdc_prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic mdio_q, mdio_d;

  always_comb begin
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
    mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
    mdc_prev_d  = mdc_sync_q[SYNC_STAGES-1];
    rise_d      = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
    fall_d      = ~mdc_sync_q[SYNC_STAGES-1] & mdc_prev_q;
    // Delayed by the same flop as the pulses so a rise pulse sees the bit it strobes.
    mdio_d      = mdio_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mdio_q      <= 1'b0;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      mdio_q      <= mdio_d;
    end
  end

  assign mdc_rise = rise_q;
  assign mdc_fall = fall_q;
  assign mdio_s   = mdio_q;
endmodule

// File: rtl/mdio_slave.sv
// PHY-side Clause 22 MDIO responder: decodes frames sampled on MDC rising edges and
// drives read data on falling edges. Optional MDIO_SLAVE_PREAMBLE_SUPPRESS_EN accepts short preambles.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PHYAD_W-1:0]   phy_addr,
  input  logic                 mdc_i,
  input  logic                 mdio_i,
  output logic                 mdio_o,
  output logic                 mdio_t,
  output logic [REGAD_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]    reg_wr_data,
  output logic                 reg_wr_valid,
  output logic                 reg_rd_req,
  input  logic [DATA_W-1:0]    reg_rd_data,
  output logic                 busy,
  output logic                 frame_err
);
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_LEN);

  logic mdc_rise, mdc_fall, mdio_s;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .mdc_i   (mdc_i),
    .mdio_i  (mdio_i),
    .mdc_rise(mdc_rise),
    .mdc_fall(mdc_fall),
    .mdio_s  (mdio_s)
  );

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [HDR_W-2:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               is_rd_q, is_rd_d;
  logic               ta_q, ta_d;
  logic [REGAD_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]  reg_wr_data_q, reg_wr_data_d;
  logic               reg_wr_valid_q, reg_wr_valid_d;
  logic               reg_rd_req_q, reg_rd_req_d;
  logic               frame_err_q, frame_err_d;
  logic               mdio_o_q, mdio_o_d;
  logic               mdio_t_q, mdio_t_d;
  logic               busy_q, busy_d;

  logic               pre_ok;
  logic [HDR_W-1:0]   hdr_full;
  logic [1:0]         hdr_op;
  logic [PHYAD_W-1:0] hdr_phyad;
  logic [REGAD_W-1:0] hdr_regad;

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (pre_cnt_q != '0);
`else
  assign pre_ok = (pre_cnt_q == PRE_MAX);
`endif

  assign hdr_full  = {hdr_q, mdio_s};
  assign hdr_op    = hdr_full[HDR_W-1 -: 2];
  assign hdr_phyad = hdr_full[REGAD_W +: PHYAD_W];
  assign hdr_regad = hdr_full[REGAD_W-1:0];

  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    frm_cnt_d      = frm_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    hdr_d          = hdr_q;
    shift_d        = shift_q;
    is_rd_d        = is_rd_q;
    ta_d           = ta_q;
    reg_addr_d     = reg_addr_q;
    reg_wr_data_d  = reg_wr_data_q;
    reg_wr_valid_d = 1'b0;
    reg_rd_req_d   = 1'b0;
    frame_err_d    = 1'b0;
    mdio_o_d       = mdio_o_q;
    mdio_t_d       = mdio_t_q;

    if (mdc_rise) frm_cnt_d = frm_cnt_q + 5'd1;

    unique case (state_q)
      ST_PREAMBLE: begin
        if (mdc_rise) begin
          if (mdio_s) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end else if (pre_ok) begin
            // This 0 is ST bit 0; the count restarts so every frame needs its own preamble.
            state_d   = ST_START;
            frm_cnt_d = 5'd1;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
      end
      ST_START: begin
        if (mdc_rise) begin
          if (mdio_s) begin
            state_d = ST_HEADER;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_PREAMBLE;
          end
        end
      end
      ST_HEADER: begin
        if (mdc_rise) begin
          hdr_d = hdr_full[HDR_W-2:0];
          if (frm_cnt_q == CNT_HDR_LAST) begin
            if (hdr_op == 2'b00) begin
              frame_err_d = 1'b1;
              state_d     = ST_SKIP;
            end else if (hdr_phyad != phy_addr) begin
              state_d = ST_SKIP;
            end else begin
              reg_addr_d   = hdr_regad;
              is_rd_d      = (hdr_op != OP_WRITE);
              reg_rd_req_d = (hdr_op != OP_WRITE);
              state_d      = ST_TA;
            end
          end
        end
      end
      ST_TA: begin
        if (mdc_rise && !is_rd_q) begin
          if (frm_cnt_q == CNT_TA1) begin
            ta_d = mdio_s;
          end else if (frm_cnt_q == CNT_TA2) begin
            if ({ta_q, mdio_s} == TA_WRITE) begin
              state_d = ST_WDATA;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_SKIP;
            end
          end
        end
        // Falling edge after TA bit 1 was sampled opens TA bit 2: take the bus, drive 0.
        if (mdc_fall && is_rd_q && (frm_cnt_q == CNT_TA2)) begin
          shift_d  = reg_rd_data;
          mdio_t_d = 1'b0;
          mdio_o_d = 1'b0;
          rd_cnt_d = '0;
          state_d  = ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (mdc_rise) begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (frm_cnt_q == CNT_LAST) begin
            reg_wr_data_d  = {shift_q[DATA_W-2:0], mdio_s};
            reg_wr_valid_d = 1'b1;
            state_d        = ST_PREAMBLE;
          end
        end
      end
      ST_RDATA: begin
        if (mdc_fall) begin
          if (rd_cnt_q == RD_BITS) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b0;
            state_d  = ST_PREAMBLE;
          end else begin
            mdio_o_d = shift_q[DATA_W-1];
            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            rd_cnt_d = rd_cnt_q + 5'd1;
          end
        end
      end
      ST_SKIP: begin
        if (mdc_rise && (frm_cnt_q == CNT_LAST)) state_d = ST_PREAMBLE;
      end
      default: state_d = ST_PREAMBLE;
    endcase

    busy_d = (state_q != ST_PREAMBLE) && (state_d != ST_PREAMBLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_PREAMBLE;
      pre_cnt_q      <= '0;
      frm_cnt_q      <= '0;
      rd_cnt_q       <= '0;
      hdr_q          <= '0;
      shift_q        <= '0;
      is_rd_q        <= 1'b0;
      ta_q           <= 1'b0;
      reg_addr_q     <= '0;
      reg_wr_data_q  <= '0;
      reg_wr_valid_q <= 1'b0;
      reg_rd_req_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      mdio_o_q       <= 1'b0;
      mdio_t_q       <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      frm_cnt_q      <= frm_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      hdr_q          <= hdr_d;
      shift_q        <= shift_d;
      is_rd_q        <= is_rd_d;
      ta_q           <= ta_d;
      reg_addr_q     <= reg_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      reg_wr_valid_q <= reg_wr_valid_d;
      reg_rd_req_q   <= reg_rd_req_d;
      frame_err_q    <= frame_err_d;
      mdio_o_q       <= mdio_o_d;
      mdio_t_q       <= mdio_t_d;
      busy_q         <= busy_d;
    end
  end

  assign mdio_o       = mdio_o_q;
  assign mdio_t       = mdio_t_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign reg_wr_valid = reg_wr_valid_q;
  assign reg_rd_req   = reg_rd_req_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
endmodule
